// File: rtl/mips32_pkg.sv
// Definitions shared between the MIPS32 core and its fetch front end:
// opcodes, word width, default instruction-memory address width.
package mips32_pkg;

    localparam int WORD_W     = 32;
    localparam int DEFAULT_AW = 10;

    typedef enum logic [5:0] {
        OP_ADD   = 6'b000000,
        OP_SUB   = 6'b000001,
        OP_AND   = 6'b000010,
        OP_OR    = 6'b000011,
        OP_SLT   = 6'b000100,
        OP_MUL   = 6'b000101,
        OP_LW    = 6'b001000,
        OP_SW    = 6'b001001,
        OP_ADDI  = 6'b001010,
        OP_SUBI  = 6'b001011,
        OP_SLTI  = 6'b001100,
        OP_BNEQZ = 6'b001101,
        OP_BEQZ  = 6'b001110,
        OP_HLT   = 6'b111111
    } opcode_e;

    typedef enum logic {
        ST_FETCH  = 1'b0,
        ST_HALTED = 1'b1
    } fetch_state_e;

    // One fetch-queue entry: instruction word plus the PC that follows it.
    typedef struct packed {
        logic [WORD_W-1:0] ir;
        logic [WORD_W-1:0] npc;
    } fq_entry_t;

    function automatic logic is_hlt(input logic [WORD_W-1:0] ir);
        return ir[31:26] == OP_HLT;
    endfunction

endpackage

// File: rtl/mips32_fifo.sv
// Synchronous FIFO with flush and a registered head word, so the consumer
// sees the oldest entry straight from a flop.
module mips32_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 64
) (
    input  logic                     clk1,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [W-1:0]             wdata,
    input  logic                     pop,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count,
    output logic [W-1:0]             head
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_next;
    logic [CW-1:0] count_q;
    logic [W-1:0]  head_q;
    logic          pop_ok;

    assign pop_ok  = pop && (count_q != '0);
    assign rd_next = rd_ptr_q + PW'(1);

    // NOTE: storage carries no reset; validity is tracked by count_q alone,
    // which keeps the array a plain register file / RAM.
    always_ff @(posedge clk1) begin
        if (push && !flush) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else if (flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_next;
            end
            count_q <= count_q + CW'(push) - CW'(pop_ok);
            // Head follows the new oldest entry: bypass when the queue drains to empty.
            if ((count_q - CW'(pop_ok)) == '0) begin
                if (push) begin
                    head_q <= wdata;
                end
            end else if (pop_ok) begin
                head_q <= mem_q[rd_next];
            end
        end
    end

    assign count = count_q;
    assign head  = head_q;

endmodule

// File: rtl/mips32_fetch_queue.sv
// Instruction fetch front end: owns the PC, issues one-cycle-latency reads,
// queues {ir, npc} for ID, and handles branch redirects and HLT.
module mips32_fetch_queue
    import mips32_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = DEFAULT_AW
) (
    input  logic              clk1,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [AW-1:0]     imem_addr,
    input  logic [WORD_W-1:0] imem_rdata,
    input  logic              redirect,
    input  logic [WORD_W-1:0] redirect_pc,
    output logic              out_valid,
    output logic [WORD_W-1:0] out_ir,
    output logic [WORD_W-1:0] out_npc,
    input  logic              out_ready,
    output logic              halted
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_e      state_q;
    logic [WORD_W-1:0] pc_q;
    logic [WORD_W-1:0] req_addr_q;
    logic              inflight_q;

    logic [CW-1:0]     fifo_count;
    logic              push;
    logic              hlt_seen;
    fq_entry_t         push_entry;
    fq_entry_t         head;
    logic [$bits(fq_entry_t)-1:0] head_bits;

    // Gated by rst_n so the request drops the moment reset asserts.
    assign imem_req = rst_n && (state_q == ST_FETCH) && !redirect &&
                      ((32'(fifo_count) + 32'(inflight_q)) < 32'(DEPTH));
    assign imem_addr = pc_q[AW-1:0];

    assign push       = inflight_q && !redirect;
    assign hlt_seen   = push && is_hlt(imem_rdata);
    assign push_entry = '{ir: imem_rdata, npc: req_addr_q + 32'd1};

    // A request issued alongside a returning HLT is killed by clearing
    // inflight and rewinding pc to the word after the HLT.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_FETCH;
            pc_q       <= '0;
            req_addr_q <= '0;
            inflight_q <= 1'b0;
        end else if (redirect) begin
            state_q    <= ST_FETCH;
            pc_q       <= redirect_pc;
            inflight_q <= 1'b0;
        end else if (hlt_seen) begin
            state_q    <= ST_HALTED;
            pc_q       <= req_addr_q + 32'd1;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= imem_req;
            if (imem_req) begin
                pc_q       <= pc_q + 32'd1;
                req_addr_q <= pc_q;
            end
        end
    end

    mips32_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(fq_entry_t))
    ) u_fifo (
        .clk1  (clk1),
        .rst_n (rst_n),
        .push  (push),
        .wdata (push_entry),
        .pop   (out_ready),
        .flush (redirect),
        .count (fifo_count),
        .head  (head_bits)
    );

    assign head      = fq_entry_t'(head_bits);
    assign out_valid = (fifo_count != '0);
    assign out_ir    = head.ir;
    assign out_npc   = head.npc;
    assign halted    = (state_q == ST_HALTED);

endmodule

// File: tb/tb_mips32_fetch_queue.sv
// Directed bench for mips32_fetch_queue: stimulus queues the words ID should
// receive, a monitor pops and compares on every accepted handshake.
module tb_mips32_fetch_queue;
    import mips32_pkg::*;

    localparam int DEPTH = 4;
    localparam int AW    = 10;
    localparam logic [31:0] HLT_WORD = 32'hFC00_0002;

    logic        clk1 = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [AW-1:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic [31:0] out_ir;
    logic [31:0] out_npc;
    logic        out_ready;
    logic        halted;

    logic [31:0] mem [1024];
    fq_entry_t   expq [$];
    int          n_checks = 0;
    int          n_pass   = 0;

    always #5 clk1 = ~clk1;

    always @(posedge clk1) begin
        if (imem_req) imem_rdata <= mem[imem_addr];
    end

    mips32_fetch_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk1        (clk1),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .out_valid   (out_valid),
        .out_ir      (out_ir),
        .out_npc     (out_npc),
        .out_ready   (out_ready),
        .halted      (halted)
    );

    function automatic logic [31:0] w(input int a);
        return 32'h2000_0000 | 32'(a & 1023);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic expect_word(input logic [31:0] ir, input logic [31:0] npc);
        expq.push_back('{ir: ir, npc: npc});
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk1);
    endtask

    // Monitor: compare every word ID actually accepts against the queue.
    initial begin
        fq_entry_t e;
        forever begin
            @(negedge clk1);
            #2;
            if (rst_n && out_valid && out_ready && !redirect) begin
                if (expq.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_word: got ir=%h npc=%h, none expected", out_ir, out_npc);
                end else begin
                    e = expq.pop_front();
                    check("head_ir", out_ir, e.ir);
                    check("head_npc", out_npc, e.npc);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = w(i);
        rst_n = 1'b0; out_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;

        step(2); #1;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_halted", 32'(halted), 0);
        check("rst_out_ir", out_ir, 0);
        check("rst_out_npc", out_npc, 0);
        check("rst_imem_req", 32'(imem_req), 0);

        // Stream from reset: first word visible in cycle 2, one per cycle.
        for (int i = 0; i < 4; i++) expect_word(w(i), 32'(i + 1));
        step(1); rst_n = 1'b1; out_ready = 1'b1; #1;
        check("c0_imem_req", 32'(imem_req), 1);
        check("c0_imem_addr", 32'(imem_addr), 0);
        check("c0_out_valid", 32'(out_valid), 0);
        step(1); #1;
        check("c1_out_valid", 32'(out_valid), 0);
        for (int i = 0; i < 4; i++) begin
            step(1); #1;
            check("stream_out_valid", 32'(out_valid), 1);
        end

        // Back-pressure: fill to DEPTH, then drain.
        for (int i = 4; i < 7; i++) expect_word(w(i), 32'(i + 1));
        step(1); out_ready = 1'b0;
        step(4); #1;
        check("full_imem_req", 32'(imem_req), 0);
        check("full_count", 32'(dut.fifo_count), 4);
        check("full_out_valid", 32'(out_valid), 1);
        step(2); out_ready = 1'b1; #1;
        check("drain_c0_imem_req", 32'(imem_req), 0);
        step(1); #1;
        check("resume_imem_req", 32'(imem_req), 1);
        check("resume_imem_addr", 32'(imem_addr), 8);

        // Redirect with 2 queued entries and one in flight.
        step(2); redirect = 1'b1; redirect_pc = 32'h20; #1;
        check("redir_imem_req", 32'(imem_req), 0);
        check("redir_pre_count", 32'(dut.fifo_count), 2);
        check("redir_pre_inflight", 32'(dut.inflight_q), 1);
        for (int j = 0; j < 3; j++) expect_word(w(32'h20 + j), 32'(32'h21 + j));
        step(1); redirect = 1'b0; #1;
        check("redir_next_out_valid", 32'(out_valid), 0);
        check("redir_next_imem_req", 32'(imem_req), 1);
        check("redir_next_imem_addr", 32'(imem_addr), 32'h20);

        // HLT at address 2: deliver 0, 1, HLT; word 3 is dropped.
        step(5); mem[2] = HLT_WORD; redirect = 1'b1; redirect_pc = 0;
        expect_word(w(0), 1); expect_word(w(1), 2); expect_word(HLT_WORD, 3);
        step(1); redirect = 1'b0;
        step(3); #1;
        check("pre_hlt_halted", 32'(halted), 0);
        step(1); #1;
        check("hlt_halted", 32'(halted), 1);
        check("hlt_imem_req", 32'(imem_req), 0);
        check("hlt_pc_rewind", 32'(imem_addr), 3);
        step(3); #1;
        check("hlt_hold_halted", 32'(halted), 1);
        check("hlt_hold_imem_req", 32'(imem_req), 0);
        check("hlt_drained_valid", 32'(out_valid), 0);

        // Redirect out of HALTED.
        step(1); mem[2] = w(2); redirect = 1'b1; redirect_pc = 0; #1;
        check("unhalt_redir_req", 32'(imem_req), 0);
        expect_word(w(0), 1); expect_word(w(1), 2);
        step(1); redirect = 1'b0; #1;
        check("unhalt_halted", 32'(halted), 0);
        check("unhalt_imem_req", 32'(imem_req), 1);
        check("unhalt_imem_addr", 32'(imem_addr), 0);

        // Address wrap: 1023 then 0, npc not truncated.
        step(4); redirect = 1'b1; redirect_pc = 1023;
        expect_word(w(1023), 1024); expect_word(w(0), 1025);
        step(1); redirect = 1'b0; #1;
        check("wrap_req_a", 32'(imem_req), 1);
        check("wrap_addr_a", 32'(imem_addr), 1023);
        step(1); #1;
        check("wrap_req_b", 32'(imem_req), 1);
        check("wrap_addr_b", 32'(imem_addr), 0);

        // Fill, then async reset between clock edges.
        step(3); out_ready = 1'b0;
        step(6); #1;
        check("prerst_imem_req", 32'(imem_req), 0);
        check("prerst_count", 32'(dut.fifo_count), 4);
        check("prerst_out_valid", 32'(out_valid), 1);
        #2; rst_n = 1'b0; #1;
        check("arst_out_valid", 32'(out_valid), 0);
        check("arst_imem_req", 32'(imem_req), 0);
        check("arst_halted", 32'(halted), 0);
        expect_word(w(0), 1); expect_word(w(1), 2);
        step(1); rst_n = 1'b1; out_ready = 1'b1; #1;
        check("rerst_imem_req", 32'(imem_req), 1);
        check("rerst_imem_addr", 32'(imem_addr), 0);
        step(4); out_ready = 1'b0;
        step(2); #1;
        check("scoreboard_empty", 32'(expq.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
